pin_uart_sender: RTL and testbench

//  UART transmitter for one brute-force PIN attempt. It sits downstream of the four digit counters
//  and upstream of the target board's RX pin. On a start request it latches the 4 PIN bytes and

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_byte_tx.sv | 117 +++++++++++
 rtl/pin_uart_sender.sv | 76 +++++++
 tb/tb_pin_uart_sender.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame size, baud divider and serializer state encoding.
package uart_pkg;

    localparam logic        UART_IDLE      = 1'b1;
    localparam logic        UART_START     = 1'b0;
    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer. A load accepted on the edge that ends a stop bit chains the
// next frame with no idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done_c
);

    localparam int unsigned    CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_d;
    logic             busy_d;
    logic             bit_end_c;

    assign bit_end_c = (cnt_q == CNT_LAST);

    // Next-state, counters and next line level
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        tx_d        = tx;
        byte_done_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d  = UART_IDLE;
                cnt_d = '0;
                bit_d = '0;
                if (load) begin
                    state_d = ST_START;
                    tx_d    = UART_START;
                    shreg_d = data;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        bit_d   = '0;
                        tx_d    = UART_IDLE;
                    end else begin
                        bit_d   = bit_q + 3'(1);
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    cnt_d       = '0;
                    byte_done_c = 1'b1;
                    if (load) begin
                        state_d = ST_START;
                        tx_d    = UART_START;
                        shreg_d = data;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = UART_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = UART_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx      <= UART_IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: rtl/pin_uart_sender.sv
// Sends one latched 4-byte PIN attempt (plus optional terminator) as back-to-back 8N1 frames
// and reports busy/done for attempt sequencing.
module pin_uart_sender
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 12_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned SEND_EOL = 1,
    parameter logic [7:0]  EOL_BYTE = 8'h0D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pin_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [2:0]  LAST_IDX     = (SEND_EOL != 0) ? 3'd4 : 3'd3;

    logic [31:0] pin_q;
    logic [2:0]  idx_q;
    logic        byte_busy;
    logic        byte_done_c;
    logic        accept_c;
    logic        last_c;
    logic        advance_c;
    logic        load_c;
    logic [7:0]  load_data_c;

    assign accept_c    = start && !busy && !byte_busy;
    assign last_c      = (idx_q == LAST_IDX);
    assign advance_c   = byte_done_c && !last_c;
    assign load_c      = accept_c || advance_c;
    // The first byte comes straight from pin_in; later bytes from the latched copy
    assign load_data_c = accept_c         ? pin_in[7:0] :
                         (idx_q == 3'd3)  ? EOL_BYTE    : pin_q[15:8];

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .data       (load_data_c),
        .tx         (tx),
        .busy       (byte_busy),
        .byte_done_c(byte_done_c)
    );

    // Byte sequencing, PIN latch and attempt status
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_q <= '0;
            idx_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= byte_done_c && last_c;
            if (accept_c) begin
                pin_q <= pin_in;
                idx_q <= '0;
                busy  <= 1'b1;
            end else if (advance_c) begin
                pin_q <= {8'h00, pin_q[31:8]};
                idx_q <= idx_q + 3'(1);
            end else if (byte_done_c) begin
                idx_q <= '0;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pin_uart_sender.sv
// Randomized bench for pin_uart_sender: instance 0 sends a terminator, instance 1 does not.
module tb_pin_uart_sender;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int CAP_N = 1024;

    logic        clk = 1'b0;
    logic        rst_v   [2];
    logic        start_v [2];
    logic [31:0] pin_v   [2];
    logic        tx_v    [2];
    logic        busy_v  [2];
    logic        done_v  [2];

    always #5 clk = ~clk;

    pin_uart_sender #(.CLK_HZ(1_000_000), .BAUD(250_000), .SEND_EOL(1), .EOL_BYTE(8'h0D)) u_eol (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .pin_in(pin_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    pin_uart_sender #(.CLK_HZ(1_000_000), .BAUD(250_000), .SEND_EOL(0), .EOL_BYTE(8'h0D)) u_noeol (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .pin_in(pin_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: each attempt is a timeline t = cycles since the accepting edge
    bit          m_active [2];
    bit          m_done   [2];
    int          m_t      [2];
    logic [39:0] m_bytes  [2];

    logic cap [CAP_N];
    int   cap_len;
    int   cap_inst;
    bit   cap_on;
    int   busy_n;
    int   done_n;
    int   done_at [$];

    function automatic int nbytes(input int i);
        return (i == 0) ? 5 : 4;
    endfunction

    function automatic logic frame_bit(input logic [39:0] bytes, input int t);
        int         k;
        int         f;
        logic [7:0] b;
        k = t / FRAME;
        f = (t % FRAME) / CPB;
        b = bytes[8*k +: 8];
        if (f == 0) return 1'b0;
        if (f == 9) return 1'b1;
        return b[f-1];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int i);
        if (rst_v[i]) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b0;
        end else if (m_active[i]) begin
            m_done[i] = 1'b0;
            m_t[i]++;
            if (m_t[i] == nbytes(i) * FRAME) begin
                m_active[i] = 1'b0;
                m_done[i]   = 1'b1;
            end
        end else begin
            m_done[i] = 1'b0;
            if (start_v[i]) begin
                m_active[i] = 1'b1;
                m_t[i]      = 0;
                m_bytes[i]  = {((i == 0) ? 8'h0D : 8'h00), pin_v[i]};
            end
        end
    endtask

    // One clock: advance the model on the rising edge, compare both DUTs on the falling edge
    task automatic tick();
        logic exp_tx;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_tx = m_active[i] ? frame_bit(m_bytes[i], m_t[i]) : 1'b1;
            chk($sformatf("tx%0d", i),   64'(tx_v[i]),   64'(exp_tx));
            chk($sformatf("busy%0d", i), 64'(busy_v[i]), 64'(m_active[i]));
            chk($sformatf("done%0d", i), 64'(done_v[i]), 64'(m_done[i]));
        end
        if (cap_on && cap_len < CAP_N) begin
            cap[cap_len] = tx_v[cap_inst];
            if (busy_v[cap_inst]) busy_n++;
            if (done_v[cap_inst]) begin
                done_n++;
                done_at.push_back(cap_len);
            end
            cap_len++;
        end
    endtask

    task automatic cap_begin(input int i);
        cap_inst = i;
        cap_len  = 0;
        busy_n   = 0;
        done_n   = 0;
        done_at.delete();
        cap_on   = 1'b1;
    endtask

    // Pulse start for one cycle; cap[0] holds tx in the cycle right after the accepting edge
    task automatic start_pulse(input int i, input logic [31:0] pin);
        chk("pre_start_tx", 64'(tx_v[i]), 64'(1));
        pin_v[i]   = pin;
        start_v[i] = 1'b1;
        cap_begin(i);
        tick();
        start_v[i] = 1'b0;
        chk("start_latency", 64'(cap[0]), 64'(0));
    endtask

    task automatic tick_until_len(input int n);
        while (cap_len < n) tick();
    endtask

    // Mid-bit UART receive over the captured line
    task automatic decode(input int nb, input logic [39:0] exp_bytes);
        int         pos;
        logic [7:0] b;
        pos = 0;
        for (int k = 0; k < nb; k++) begin
            while (pos < cap_len && cap[pos] != 1'b0) pos++;
            chk($sformatf("rx_found%0d", k), 64'(pos + 39 < cap_len), 64'(1));
            if (pos + 39 >= cap_len) return;
            chk($sformatf("rx_start%0d", k), 64'(cap[pos + 2]), 64'(0));
            for (int j = 0; j < 8; j++) b[j] = cap[pos + CPB*(j+1) + 2];
            chk($sformatf("rx_byte%0d", k), 64'(b), 64'(exp_bytes[8*k +: 8]));
            chk($sformatf("rx_stop%0d", k), 64'(cap[pos + 38]), 64'(1));
            pos += FRAME - 1;
        end
    endtask

    task automatic check_runs(input int upto);
        int run;
        int bad;
        run = 1;
        bad = 0;
        for (int c = 1; c < upto; c++) begin
            if (cap[c] == cap[c-1]) run++;
            else begin
                if (run % CPB != 0) bad++;
                run = 1;
            end
        end
        if (run % CPB != 0) bad++;
        chk("run_mult4", 64'(bad), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pin_a;
        logic [31:0] pin_b;
        int          guard;
        cap_on = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rst_v[i]    = 1'b1;
            start_v[i]  = 1'b0;
            pin_v[i]    = '0;
            m_active[i] = 1'b0;
            m_done[i]   = 1'b0;
            m_t[i]      = 0;
            m_bytes[i]  = '0;
        end
        repeat (3) tick();
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;

        // Idle after reset
        cap_begin(0);
        repeat (20) tick();
        chk("idle_busy", 64'(busy_n), 64'(0));
        chk("idle_done", 64'(done_n), 64'(0));
        chk("idle_tx", 64'(tx_v[0]), 64'(1));

        // Fixed PIN with terminator
        start_pulse(0, 32'h34333231);
        tick_until_len(220);
        chk("burst_busy", 64'(busy_n), 64'(200));
        chk("burst_done", 64'(done_n), 64'(1));
        if (done_at.size() > 0) chk("done_pos", 64'(done_at[0]), 64'(200));
        decode(5, 40'h0D34333231);
        check_runs(200);

        // Start held high on the no-terminator instance
        pin_v[1]   = $urandom;
        start_v[1] = 1'b1;
        cap_begin(1);
        repeat (500) tick();
        chk("held_done_cnt", 64'(done_n), 64'(3));
        chk("held_busy_cnt", 64'(busy_n), 64'(497));
        if (done_at.size() >= 2) begin
            chk("held_first_done", 64'(done_at[0]), 64'(160));
            chk("held_period", 64'(done_at[1] - done_at[0]), 64'(161));
        end
        decode(4, {8'h00, pin_v[1]});
        start_v[1] = 1'b0;
        guard = 0;
        while (busy_v[1] && guard < 300) begin
            tick();
            guard++;
        end
        chk("held_drain", 64'(busy_v[1]), 64'(0));
        tick();

        // Change pin_in and retrigger mid-burst
        pin_a = $urandom;
        pin_b = ~pin_a;
        start_pulse(0, pin_a);
        repeat (69) tick();
        pin_v[0]   = pin_b;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick_until_len(230);
        chk("retrig_busy", 64'(busy_n), 64'(200));
        chk("retrig_done", 64'(done_n), 64'(1));
        decode(5, {8'h0D, pin_a});

        // Reset during data bit 3 of byte 2
        pin_a = $urandom;
        start_pulse(0, pin_a);
        repeat (96) tick();
        rst_v[0] = 1'b1;
        tick();
        chk("rst_tx", 64'(tx_v[0]), 64'(1));
        chk("rst_busy", 64'(busy_v[0]), 64'(0));
        chk("rst_done", 64'(done_v[0]), 64'(0));
        rst_v[0] = 1'b0;
        cap_begin(0);
        repeat (250) tick();
        chk("abort_done", 64'(done_n), 64'(0));
        chk("abort_busy", 64'(busy_n), 64'(0));

        pin_b = $urandom;
        start_pulse(0, pin_b);
        tick_until_len(220);
        chk("clean_busy", 64'(busy_n), 64'(200));
        chk("clean_done", 64'(done_n), 64'(1));
        decode(5, {8'h0D, pin_b});
        check_runs(200);

        cap_on = 1'b0;
        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
